// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared master indices and read-return tag for the RAM arbiter
package ram_arb_pkg;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
  typedef struct packed {
    logic valid;
    logic id;
  } rtag_t;
endpackage

// File: rtl/ram_sdp_arbiter_if.sv
// ram_sdp_arbiter_if: one master's command/response bundle toward the RAM arbiter
interface ram_sdp_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter with fixed-priority override
module rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       fixed,
  output logic [1:0] gnt,
  output logic       ptr
);
  assign gnt[0] = req[0] & (~req[1] | fixed | ~ptr);
  assign gnt[1] = req[1] & ~gnt[0];
  // pointer moves to the loser only when both requesters contend
  always_ff @(posedge clk) begin
    if (!resetn) ptr <= 1'b0;
    else if (&req & ~fixed) ptr <= ~ptr;
  end
endmodule

// File: rtl/ram_sdp_arbiter.sv
// ram_sdp_arbiter: shares a simple dual-port RAM between two masters with write-first forwarding
module ram_sdp_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  ram_sdp_arbiter_if.slave      m0,
  ram_sdp_arbiter_if.slave      m1,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_q
);
  logic [1:0]            wreq, rreq, wgnt, rgnt;
  logic                  unused_wptr, unused_rptr;
  logic [ADDR_WIDTH-1:0] waddr, raddr, raddr_q;
  logic                  fwd_hit, live;
  logic [DATA_WIDTH-1:0] fwd_data, rd;
  rtag_t                 tag;
  assign wreq = {2{resetn}} & {m1.req & m1.we, m0.req & m0.we};
  assign rreq = {2{resetn}} & {m1.req & ~m1.we, m0.req & ~m0.we};
  rr_arb2 u_warb (
    .clk    (clk),
    .resetn (resetn),
    .req    (wreq),
    .fixed  (FIXED_PRIO != 0),
    .gnt    (wgnt),
    .ptr    (unused_wptr)
  );
  rr_arb2 u_rarb (
    .clk    (clk),
    .resetn (resetn),
    .req    (rreq),
    .fixed  (FIXED_PRIO != 0),
    .gnt    (rgnt),
    .ptr    (unused_rptr)
  );
  assign m0.gnt         = wgnt[M0] | rgnt[M0];
  assign m1.gnt         = wgnt[M1] | rgnt[M1];
  assign waddr          = wgnt[M1] ? m1.addr : m0.addr;
  assign raddr          = rgnt[M1] ? m1.addr : m0.addr;
  assign ram_we         = |wgnt;
  assign ram_write_addr = waddr;
  assign ram_data       = wgnt[M1] ? m1.wdata : m0.wdata;
  assign ram_read_addr  = |rgnt ? raddr : raddr_q;
  // read-return tag, same-cycle forwarding capture and read-address hold
  always_ff @(posedge clk) begin
    fwd_data <= ram_data;
    if (!resetn) begin
      tag     <= '0;
      fwd_hit <= 1'b0;
      raddr_q <= '0;
    end else begin
      tag     <= {|rgnt, rgnt[M1]};
      fwd_hit <= |rgnt & |wgnt & (raddr == waddr);
      raddr_q <= ram_read_addr;
    end
  end
  assign live      = tag.valid & resetn;
  assign rd        = live ? (fwd_hit ? fwd_data : ram_q) : '0;
  assign m0.rvalid = live & (tag.id == M0);
  assign m1.rvalid = live & (tag.id == M1);
  assign m0.rdata  = rd;
  assign m1.rdata  = rd;
endmodule
